// File: rtl/dot_product_engine.sv
// Multi-lane dot-product engine (a.b per lane, optional old-output preload); DOT_PRODUCT_SAT_EN saturates written words.
// Latency vec_len+3 cycles start-to-done (+1 with load_old_output); no backpressure, start only taken in IDLE.
module dot_product_engine #(
  parameter int Addr_Width     = 4,
  parameter int Para_Deg       = 2,
  parameter int Data_Width_In  = 8,
  parameter int Data_Width_Out = 16,
  parameter int Acc_Width      = 2 * Data_Width_Out
) (
  input  logic                                 clk,
  input  logic                                 Comp_reset,
  input  logic                                 start,
  input  logic                                 load_old_output,
  input  logic [Addr_Width:0]                  vec_len,
  input  logic [Addr_Width-1:0]                in_base_addr,
  input  logic [Addr_Width-1:0]                out_addr,
  output logic                                 busy,
  output logic                                 done,
  output logic [2:0]                           state,
  output logic                                 in_rd_en,
  output logic [Addr_Width-1:0]                in_rd_addr,
  input  logic [Para_Deg*Data_Width_In-1:0]    in_rd_data_a,
  input  logic [Para_Deg*Data_Width_In-1:0]    in_rd_data_b,
  output logic                                 out_rd_en,
  output logic [Addr_Width-1:0]                out_rd_addr,
  input  logic [Para_Deg*Data_Width_Out-1:0]   out_rd_data,
  output logic                                 out_wr_en,
  output logic [Addr_Width-1:0]                out_wr_addr,
  output logic [Para_Deg*Data_Width_Out-1:0]   out_wr_data,
  output logic [Para_Deg*Acc_Width-1:0]        result
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LOAD_OLD = 3'd1;
  localparam logic [2:0] ISSUE    = 3'd2;
  localparam logic [2:0] DRAIN    = 3'd3;
  localparam logic [2:0] WRITE    = 3'd4;
  localparam logic [2:0] DONE     = 3'd5;

  localparam logic [Addr_Width:0]   CNT_ONE  = 1;
  localparam logic [Addr_Width:0]   CNT_ZERO = '0;
  localparam logic [Addr_Width-1:0] ADDR_ONE = 1;

  logic [Addr_Width:0]                      cnt_q;
  logic [Addr_Width-1:0]                    rd_addr_q;
  logic [Addr_Width-1:0]                    out_addr_q;
  logic                                     rd_vld_q;
  logic                                     old_vld_q;
  logic [Para_Deg-1:0][Acc_Width-1:0]       acc_q;
  logic [Para_Deg-1:0][2*Data_Width_In-1:0] prod;

  always_ff @(posedge clk or posedge Comp_reset) begin
    if (Comp_reset) begin
      state      <= IDLE;
      cnt_q      <= '0;
      rd_addr_q  <= '0;
      out_addr_q <= '0;
      rd_vld_q   <= 1'b0;
      old_vld_q  <= 1'b0;
    end else begin
      // SRAM data returns one cycle after the strobe; these flags mark that cycle.
      rd_vld_q  <= (state == ISSUE);
      old_vld_q <= (state == LOAD_OLD);
      case (state)
        IDLE: begin
          if (start) begin
            cnt_q      <= vec_len;
            rd_addr_q  <= in_base_addr;
            out_addr_q <= out_addr;
            if (load_old_output)       state <= LOAD_OLD;
            else if (vec_len != CNT_ZERO) state <= ISSUE;
            else                       state <= DRAIN;
          end
        end
        LOAD_OLD: state <= (cnt_q != CNT_ZERO) ? ISSUE : DRAIN;
        ISSUE: begin
          rd_addr_q <= rd_addr_q + ADDR_ONE;
          cnt_q     <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) state <= DRAIN;
        end
        DRAIN:   state <= WRITE;
        WRITE:   state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < Para_Deg; i++) begin
      prod[i] = in_rd_data_a[i*Data_Width_In +: Data_Width_In] *
                in_rd_data_b[i*Data_Width_In +: Data_Width_In];
    end
  end

  always_ff @(posedge clk or posedge Comp_reset) begin
    if (Comp_reset) begin
      acc_q <= '0;
    end else if (state == IDLE && start) begin
      acc_q <= '0;
    end else if (old_vld_q) begin
      for (int i = 0; i < Para_Deg; i++)
        acc_q[i] <= Acc_Width'(out_rd_data[i*Data_Width_Out +: Data_Width_Out]);
    end else if (rd_vld_q) begin
      for (int i = 0; i < Para_Deg; i++)
        acc_q[i] <= acc_q[i] + Acc_Width'(prod[i]);
    end
  end

`ifdef DOT_PRODUCT_SAT_EN
  localparam logic [Acc_Width-1:0] WORD_MAX = Acc_Width'({Data_Width_Out{1'b1}});
`endif

  always_comb begin
    busy        = (state != IDLE);
    done        = (state == DONE);
    in_rd_en    = (state == ISSUE);
    in_rd_addr  = in_rd_en ? rd_addr_q : '0;
    out_rd_en   = (state == LOAD_OLD);
    out_rd_addr = out_rd_en ? out_addr_q : '0;
    out_wr_en   = (state == WRITE);
    out_wr_addr = out_wr_en ? out_addr_q : '0;
    out_wr_data = '0;
    result      = '0;
    for (int i = 0; i < Para_Deg; i++) begin
      result[i*Acc_Width +: Acc_Width] = acc_q[i];
      if (out_wr_en) begin
`ifdef DOT_PRODUCT_SAT_EN
        out_wr_data[i*Data_Width_Out +: Data_Width_Out] =
          (acc_q[i] > WORD_MAX) ? {Data_Width_Out{1'b1}} : acc_q[i][Data_Width_Out-1:0];
`else
        out_wr_data[i*Data_Width_Out +: Data_Width_Out] = acc_q[i][Data_Width_Out-1:0];
`endif
      end
    end
  end

endmodule

// File: tb/tb_dot_product_engine.sv
// Self-checking bench for dot_product_engine: SRAM models plus a per-job arithmetic reference.
module tb_dot_product_engine;

`ifdef DOT_PRODUCT_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk;
  logic        Comp_reset;
  logic        start;
  logic        load_old_output;
  logic [4:0]  vec_len;
  logic [3:0]  in_base_addr;
  logic [3:0]  out_addr;
  logic        busy;
  logic        done;
  logic [2:0]  state;
  logic        in_rd_en;
  logic [3:0]  in_rd_addr;
  logic [15:0] in_rd_data_a;
  logic [15:0] in_rd_data_b;
  logic        out_rd_en;
  logic [3:0]  out_rd_addr;
  logic [31:0] out_rd_data;
  logic        out_wr_en;
  logic [3:0]  out_wr_addr;
  logic [31:0] out_wr_data;
  logic [63:0] result;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  mem_a [2][16];
  logic [7:0]  mem_b [2][16];
  logic [31:0] out_mem [16];

  dot_product_engine dut (
    .clk(clk), .Comp_reset(Comp_reset), .start(start), .load_old_output(load_old_output),
    .vec_len(vec_len), .in_base_addr(in_base_addr), .out_addr(out_addr),
    .busy(busy), .done(done), .state(state),
    .in_rd_en(in_rd_en), .in_rd_addr(in_rd_addr),
    .in_rd_data_a(in_rd_data_a), .in_rd_data_b(in_rd_data_b),
    .out_rd_en(out_rd_en), .out_rd_addr(out_rd_addr), .out_rd_data(out_rd_data),
    .out_wr_en(out_wr_en), .out_wr_addr(out_wr_addr), .out_wr_data(out_wr_data),
    .result(result)
  );

  always #5 clk = ~clk;

  // One-cycle-latency SRAMs
  always @(posedge clk) begin
    if (in_rd_en) begin
      for (int i = 0; i < 2; i++) begin
        in_rd_data_a[i*8 +: 8] <= mem_a[i][in_rd_addr];
        in_rd_data_b[i*8 +: 8] <= mem_b[i][in_rd_addr];
      end
    end
    if (out_rd_en) out_rd_data <= out_mem[out_rd_addr];
    if (out_wr_en) out_mem[out_wr_addr] <= out_wr_data;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_job(input string tag, input bit ld, input int len, input int base,
                         input int oaddr, input int restart_at, input int reset_at);
    logic [31:0] exp_acc [2];
    logic [31:0] exp_wr;
    logic [31:0] saved_old;
    logic [31:0] wdata;
    int nrd, nwr, nord, done_cyc, ord_cyc, waddr, ad;
    nrd = 0; nwr = 0; nord = 0; done_cyc = -1; ord_cyc = -1; waddr = -1; wdata = '0;
    saved_old = out_mem[oaddr];
    for (int i = 0; i < 2; i++) begin
      exp_acc[i] = ld ? {16'h0, saved_old[i*16 +: 16]} : 32'h0;
      for (int k = 0; k < len; k++) begin
        ad = (base + k) % 16;
        exp_acc[i] = exp_acc[i] + 32'(mem_a[i][ad]) * 32'(mem_b[i][ad]);
      end
    end
    @(negedge clk);
    start = 1'b1; load_old_output = ld; vec_len = 5'(len);
    in_base_addr = 4'(base); out_addr = 4'(oaddr);
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start = (c == restart_at);
      if (c == reset_at) begin
        Comp_reset = 1'b1;
        #1;
        chk({tag, "_rst_state"}, 64'(state), 64'd0);
        chk({tag, "_rst_busy"}, 64'(busy), 64'd0);
        chk({tag, "_rst_wr_en"}, 64'(out_wr_en), 64'd0);
        @(negedge clk);
        Comp_reset = 1'b0;
        chk({tag, "_rst_no_write"}, 64'(nwr), 64'd0);
        chk({tag, "_rst_mem_kept"}, 64'(out_mem[oaddr]), 64'(saved_old));
        return;
      end
      if (in_rd_en) begin
        chk({tag, "_rd_addr"}, 64'(in_rd_addr), 64'((base + nrd) % 16));
        nrd++;
      end
      if (out_rd_en) begin
        nord++; ord_cyc = c;
        chk({tag, "_old_addr"}, 64'(out_rd_addr), 64'(oaddr));
      end
      if (out_wr_en) begin
        nwr++; wdata = out_wr_data; waddr = int'(out_wr_addr);
      end
      if (done) begin
        done_cyc = c;
        break;
      end
    end
    chk({tag, "_done_cycle"}, 64'(done_cyc), 64'(len + 3 + int'(ld)));
    chk({tag, "_reads"}, 64'(nrd), 64'(len));
    chk({tag, "_writes"}, 64'(nwr), 64'd1);
    chk({tag, "_wr_addr"}, 64'(waddr), 64'(oaddr));
    chk({tag, "_old_reads"}, 64'(nord), 64'(ld));
    if (ld) chk({tag, "_old_cycle"}, 64'(ord_cyc), 64'd1);
    for (int i = 0; i < 2; i++) begin
      exp_wr = (SAT && exp_acc[i] > 32'd65535) ? 32'd65535 : {16'h0, exp_acc[i][15:0]};
      chk($sformatf("%s_result%0d", tag, i), 64'(result[i*32 +: 32]), 64'(exp_acc[i]));
      chk($sformatf("%s_wr_data%0d", tag, i), 64'(wdata[i*16 +: 16]), 64'(exp_wr));
    end
  endtask

  initial begin
    clk = 1'b0; Comp_reset = 1'b1; start = 1'b0; load_old_output = 1'b0;
    vec_len = '0; in_base_addr = '0; out_addr = '0;
    in_rd_data_a = '0; in_rd_data_b = '0; out_rd_data = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 16; j++) begin
        mem_a[i][j] = 8'($urandom);
        mem_b[i][j] = 8'($urandom);
      end
    for (int j = 0; j < 16; j++) out_mem[j] = $urandom;
    for (int k = 0; k < 4; k++) begin
      mem_a[0][k] = 8'(k + 1); mem_b[0][k] = 8'(k + 5);
      mem_a[1][k] = 8'd255;    mem_b[1][k] = 8'd255;
    end
    repeat (2) @(negedge clk);
    chk("reset_state", 64'(state), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_rd_en", 64'(in_rd_en), 64'd0);
    chk("reset_wr_en", 64'(out_wr_en), 64'd0);
    chk("reset_result", result, 64'd0);
    Comp_reset = 1'b0;

    run_job("t1", 1'b0, 4, 0, 3, 0, 0);
    chk("t1_lane0_lit", 64'(result[31:0]), 64'd70);
    chk("t1_lane1_lit", 64'(result[63:32]), 64'd260100);
    @(negedge clk);
    chk("t1_result_held", 64'(result[63:32]), 64'd260100);

    out_mem[5] = 32'd100;
    run_job("t2", 1'b1, 4, 0, 5, 0, 0);
    chk("t2_lane0_lit", 64'(out_mem[5][15:0]), 64'd170);

    run_job("t3a", 1'b0, 0, 7, 8, 0, 0);
    out_mem[9] = 32'h0000_1234;
    run_job("t3b", 1'b1, 0, 7, 9, 0, 0);
    chk("t3b_lane0_lit", 64'(out_mem[9][15:0]), 64'h1234);

    run_job("t4_wrap", 1'b0, 4, 14, 2, 0, 0);
    run_job("t5_restart", 1'b0, 6, 3, 4, 3, 0);
    run_job("t5_reset", 1'b0, 8, 1, 6, 0, 4);
    run_job("t5_after", 1'b1, 5, 10, 7, 0, 0);

    run_job("t6_first", 1'b0, 16, 0, 10, 0, 0);
    run_job("t6_second", 1'b0, 3, 9, 11, 0, 0);

    for (int r = 0; r < 4; r++)
      run_job($sformatf("rand%0d", r), 1'($urandom), int'($urandom_range(0, 16)),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
